i2c_slave: RTL
==============

# i2c_slave

I2C responder (slave) for the on-board I2C bus, and the bus-side counterpart of `I2C_master`. It synchronises SCL/SDA into the `CLOCK_50` domain and detects START/STOP. It matches a fixed 7-bit address, ACKs it, then either shifts in write bytes (presented as `rx_data`/`rx_valid`) or shifts out read bytes fetched via a `tx_req`/`tx_data` handshake. SCL is input-only: no clock stretching.

## Interface
- `SLAVE_ADDR`, 7'h42, 7-bit address this block answers to.
- `CLOCK_50`  in  1  system clock, sole clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `scl`  in  1  bus clock from master, asynchronous to `CLOCK_50`.
- `sda`  inout  1  open-drain: driven 0 when `sda_low`, otherwise `1'bz`; never driven 1.
- `rx_data`  out  8  last byte received in a write transfer.
- `rx_valid`  out  1  one-cycle pulse, `rx_data` updated.
- `tx_data`  in  8  byte to send in a read transfer; sampled one cycle after `tx_req`.
- `tx_req`  out  1  one-cycle pulse requesting the next read byte.
- `busy`  out  1  high from address match until STOP or abort.

## Operation
- Sync: `scl`/`sda` each pass through a 2-FF synchroniser, plus one "previous" register for edge detection.
- SCL edges: `scl_rise`/`scl_fall` are detected from the synced and previous SCL values.
- START: synced SDA falls while synced SCL is 1, in any state, including a repeated START. Effect: go to ADDR, bit counter = 0, release SDA.
- STOP: synced SDA rises while synced SCL is 1, in any state. Effect: go to IDLE, release SDA, `busy`=0.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
- Shift-register bit order is MSB first.
- ADDR:
  - Shift SDA in on each `scl_rise`.
  - After 8 bits: if bits[7:1]==SLAVE_ADDR, latch rw=bit0, assert `busy`, and go to ADDR_ACK at the next `scl_fall`. On mismatch go to WAIT_STOP and never drive SDA.
- ADDR_ACK:
  - `sda_low`=1 from the `scl_fall` ending bit 8 until the `scl_fall` ending the ACK clock.
  - If rw=1, pulse `tx_req` on entry and load `tx_data` into the shift register on the following cycle.
  - At the ACK-ending `scl_fall`, go to WRITE (rw=0) or READ (rw=1).
- WRITE:
  - Shift in 8 bits on `scl_rise`.
  - On the 8th rise: `rx_data` ← shift register, pulse `rx_valid`.
  - Then go to WRITE_ACK (drive ACK as above) and return to WRITE; this repeats indefinitely.
- READ:
  - On each `scl_fall`, `sda_low` = ~current MSB, then shift left. The first bit is placed on the ACK-ending fall.
  - After the 8th bit's fall, release SDA and go to READ_ACK.
- READ_ACK:
  - Sample SDA on `scl_rise`.
  - 0 (ACK): pulse `tx_req`, load `tx_data`, return to READ.
  - 1 (NACK): go to WAIT_STOP.
- WAIT_STOP: SDA released; only START or STOP leaves this state.
- Data phase: START/STOP during the data phase abandons any partial byte. No `rx_valid` is issued for it.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `tx_req`=0, `busy`=0, SDA released, state IDLE, synchroniser registers = 1 (idle bus).
- Edge latency: 3 `CLOCK_50` cycles from a pin edge to the detect pulse. SDA changes take effect on the cycle after `scl_fall` is detected.
- SCL timing: SCL high and low phases must each be ≥ 8 `CLOCK_50` cycles. Faster buses are unsupported.
- `rx_valid`: asserted the cycle after the 8th data `scl_rise` is detected.
- `tx_req`: `tx_data` must be valid on the cycle after `tx_req`.
- Bit counter: 3 bits, wraps 7→0 at each byte boundary.
- Simultaneous events: if START/STOP and an SCL edge are detected in the same cycle, START/STOP wins.
- Reset mid-transfer: SDA is released immediately (asynchronous) and state goes to IDLE. The block then ignores the bus until the next START.

## Structure
- Package `i2c_pkg`: state enum, `I2C_ACK`=1'b0, `I2C_NACK`=1'b1, `I2C_BITS`=8.
- Sub-module `i2c_line_sync`: 2-FF sync plus edge detect for one line. Instantiated for SCL and SDA; outputs `level`, `rise`, `fall`.
- START/STOP decode and the FSM live in `i2c_slave`.

## Test plan
- Write, address match: START, 0x84 (addr 0x42, W), byte 0xA5, STOP → ACK driven on both ACK clocks, `rx_data`=0xA5, one `rx_valid`, `busy` returns to 0 after STOP.
- Address mismatch: START, 0x86, byte 0xFF, STOP → SDA never driven, no `rx_valid`, `busy` stays 0.
- Read with NACK: START, 0x85, `tx_data`=0x3C then 0xC3, master ACKs byte 1 and NACKs byte 2 → bus carries 0x3C, 0xC3, exactly two `tx_req` pulses, SDA released after NACK.
- Repeated START: START, 0x84, 0x11, START, 0x85, read 1 byte, NACK, STOP → `rx_data`=0x11, then a read is served with no intervening STOP.
- Abort: STOP after 4 data bits of a write → no `rx_valid`, state IDLE, SDA released. A following full write of 0x5A is received correctly.
- Reset mid-transfer: assert `reset` while driving an ACK → SDA goes Z in the same cycle and all outputs take their reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C responder.
package i2c_pkg;

    localparam int unsigned I2C_BITS = 8;
    localparam int unsigned CNT_W    = 3;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(I2C_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_WAIT_STOP
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser for one bus line with registered edge pulses.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic level_q, level_d;
    logic rise_q,  rise_d;
    logic fall_q,  fall_d;

    // level_q is the previous synced value; pulses line up with its update
    always_comb begin
        sync1_d = line_in;
        sync2_d = sync1_q;
        level_d = sync2_q;
        rise_d  = sync2_q & ~level_q;
        fall_d  = ~sync2_q & level_q;
    end

    // Idle bus is high, so the chain resets to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C responder: fixed 7-bit address, write bytes out on rx_data,
// read bytes fetched through the tx_req/tx_data handshake. No clock stretching.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                scl,
    inout  wire                 sda,
    output logic [I2C_BITS-1:0] rx_data,
    output logic                rx_valid,
    input  logic [I2C_BITS-1:0] tx_data,
    output logic                tx_req,
    output logic                busy
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;
    logic start_c, stop_c;

    i2c_line_sync u_scl_sync (
        .clk     (CLOCK_50),
        .rst     (reset),
        .line_in (scl),
        .level   (scl_level),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk     (CLOCK_50),
        .rst     (reset),
        .line_in (sda),
        .level   (sda_level),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    assign start_c = sda_fall & scl_level;
    assign stop_c  = sda_rise & scl_level;

    i2c_state_e          state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [I2C_BITS-1:0] shift_q,   shift_d;
    logic [I2C_BITS-1:0] rx_data_q, rx_data_d;
    logic                rw_q,       rw_d;
    logic                pend_q,     pend_d;
    logic                sda_low_q,  sda_low_d;
    logic                busy_q,     busy_d;
    logic                rx_valid_q, rx_valid_d;
    logic                tx_req_q,   tx_req_d;
    logic                tx_ld_q,    tx_ld_d;
    logic [I2C_BITS-1:0] shift_in;

    // pend_q marks "8th bit seen / ACK decided, act on the next scl_fall"
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        pend_d     = pend_q;
        sda_low_d  = sda_low_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        tx_ld_d    = tx_req_q;
        shift_in   = {shift_q[I2C_BITS-2:0], sda_level};

        if (tx_ld_q) begin
            shift_d = tx_data;
        end

        if (start_c) begin
            state_d   = ST_ADDR;
            cnt_d     = '0;
            pend_d    = 1'b0;
            sda_low_d = 1'b0;
        end else if (stop_c) begin
            state_d   = ST_IDLE;
            pend_d    = 1'b0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: begin
                    if (scl_rise && !pend_q) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == CNT_LAST) begin
                            if (shift_q[I2C_BITS-2:0] == SLAVE_ADDR) begin
                                rw_d   = sda_level;
                                busy_d = 1'b1;
                                pend_d = 1'b1;
                            end else begin
                                state_d = ST_WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end
                    end else if (scl_fall && pend_q) begin
                        state_d   = ST_ADDR_ACK;
                        pend_d    = 1'b0;
                        sda_low_d = 1'b1;
                        tx_req_d  = rw_q;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            state_d   = ST_READ;
                            sda_low_d = ~shift_q[I2C_BITS-1];
                            shift_d   = {shift_q[I2C_BITS-2:0], 1'b0};
                            cnt_d     = 3'd1;
                        end else begin
                            state_d   = ST_WRITE;
                            sda_low_d = 1'b0;
                            cnt_d     = '0;
                        end
                    end
                end
                ST_WRITE: begin
                    if (scl_rise && !pend_q) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == CNT_LAST) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                            pend_d     = 1'b1;
                        end
                    end else if (scl_fall && pend_q) begin
                        state_d   = ST_WRITE_ACK;
                        pend_d    = 1'b0;
                        sda_low_d = 1'b1;
                    end
                end
                ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        state_d   = ST_WRITE;
                        sda_low_d = 1'b0;
                    end
                end
                // Counter wraps to 0 once all 8 bits have been placed
                ST_READ: begin
                    if (scl_fall) begin
                        if (cnt_q == '0) begin
                            state_d   = ST_READ_ACK;
                            sda_low_d = 1'b0;
                        end else begin
                            sda_low_d = ~shift_q[I2C_BITS-1];
                            shift_d   = {shift_q[I2C_BITS-2:0], 1'b0};
                            cnt_d     = cnt_q + 3'd1;
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise && !pend_q) begin
                        if (sda_level == I2C_NACK) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            tx_req_d = 1'b1;
                            pend_d   = 1'b1;
                        end
                    end else if (scl_fall && pend_q) begin
                        state_d   = ST_READ;
                        pend_d    = 1'b0;
                        sda_low_d = ~shift_q[I2C_BITS-1];
                        shift_d   = {shift_q[I2C_BITS-2:0], 1'b0};
                        cnt_d     = 3'd1;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: begin
                    sda_low_d = 1'b0;
                end
                default: begin
                    state_d   = ST_IDLE;
                    sda_low_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rw_q       <= 1'b0;
            pend_q     <= 1'b0;
            sda_low_q  <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            tx_ld_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            pend_q     <= pend_d;
            sda_low_q  <= sda_low_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            tx_ld_q    <= tx_ld_d;
        end
    end

    // Open drain: only ever pull low
    assign sda      = sda_low_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;

endmodule
